// File: rtl/config_pkg.sv
// Core configuration record shared by scoreboard-side blocks.
// Only the fields the ID allocator consumes are carried here.
package config_pkg;

    typedef struct packed {
        int unsigned NR_SB_ENTRIES;
        int unsigned TRANS_ID_BITS;
        int unsigned NrIssuePorts;
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        NR_SB_ENTRIES: 8,
        TRANS_ID_BITS: 3,
        NrIssuePorts:  2,
        NrCommitPorts: 2
    };

endpackage

// File: rtl/sb_id_allocator.sv
// Purpose: circular allocator of scoreboard transaction IDs, in-order issue and in-order retire.
// Latency: grants and IDs are combinational in the request cycle; count_o updates one edge later.
// Backpressure: grants are withheld per port when registered free slots run out or on flush.
module sb_id_allocator #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  logic                                                  flush_i,
    input  logic [CVA6Cfg.NrIssuePorts-1:0]                       alloc_req_i,
    output logic [CVA6Cfg.NrIssuePorts-1:0]                       alloc_gnt_o,
    output logic [CVA6Cfg.NrIssuePorts*CVA6Cfg.TRANS_ID_BITS-1:0] alloc_id_o,
    input  logic [CVA6Cfg.NrCommitPorts-1:0]                      commit_ack_i,
    output logic [CVA6Cfg.NrCommitPorts*CVA6Cfg.TRANS_ID_BITS-1:0] commit_id_o,
    output logic [CVA6Cfg.TRANS_ID_BITS:0]                        count_o,
    output logic                                                  full_o,
    output logic                                                  empty_o
);

    localparam int unsigned NR = CVA6Cfg.NR_SB_ENTRIES;
    localparam int unsigned TW = CVA6Cfg.TRANS_ID_BITS;
    localparam int unsigned NI = CVA6Cfg.NrIssuePorts;
    localparam int unsigned NC = CVA6Cfg.NrCommitPorts;
    localparam int unsigned CW = TW + 1;

    logic [TW-1:0] issue_ptr_q, issue_ptr_d;
    logic [TW-1:0] commit_ptr_q, commit_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free_slots;
    logic [CW-1:0] n_alloc;
    logic [CW-1:0] n_commit;
    logic          alloc_ok;
    logic          commit_ok;

    always_comb begin
        free_slots  = CW'(NR) - count_q;
        alloc_gnt_o = '0;
        n_alloc     = '0;
        alloc_ok    = !flush_i;
        // Grants form a prefix; free slots come from the registered count only.
        for (int k = 0; k < int'(NI); k++) begin
            alloc_ok       = alloc_ok && alloc_req_i[k] && (free_slots > CW'(k));
            alloc_gnt_o[k] = alloc_ok;
            if (alloc_ok) n_alloc = n_alloc + CW'(1);
        end

        n_commit  = '0;
        commit_ok = 1'b1;
        // Acks beyond current occupancy fall out of the prefix and are dropped.
        for (int k = 0; k < int'(NC); k++) begin
            commit_ok = commit_ok && commit_ack_i[k] && (count_q > CW'(k));
            if (commit_ok) n_commit = n_commit + CW'(1);
        end

        for (int k = 0; k < int'(NI); k++) begin
            alloc_id_o[k*TW +: TW] = issue_ptr_q + TW'(k);
        end
        for (int k = 0; k < int'(NC); k++) begin
            commit_id_o[k*TW +: TW] = commit_ptr_q + TW'(k);
        end

        if (flush_i) begin
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
        end else begin
            issue_ptr_d  = TW'(issue_ptr_q + n_alloc);
            commit_ptr_d = TW'(commit_ptr_q + n_commit);
            count_d      = count_q + n_alloc - n_commit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(NR));
    assign empty_o = (count_q == '0);

endmodule
